// File: rtl/key_digit_collector_pkg.sv
// Shared constants for the keypad digit collector: key codes, FSM encodings
// and the time-of-day limits used to qualify a four-digit entry.
package key_digit_collector_pkg;

   localparam logic [3:0] KEY_ALARM    = 4'hA;
   localparam logic [3:0] KEY_TIME     = 4'hB;
   localparam logic [3:0] DIGIT_MAX    = 4'd9;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE  = 2'd1;
   localparam logic [1:0] ST_HELD      = 2'd2;
   localparam logic [1:0] ST_RELEASE   = 2'd3;

   localparam logic [7:0] HOUR_MIN     = 8'd1;
   localparam logic [7:0] HOUR_MAX     = 8'd12;
   localparam logic [3:0] MIN_TENS_MAX = 4'd5;
   localparam logic [3:0] MIN_ONES_MAX = 4'd9;

   localparam logic [2:0] MAX_KEYS     = 3'd4;

   // Hour taken from the two oldest digits, minute from the two newest.
   function automatic logic time_in_range(input logic [3:0] hr_tens,
                                          input logic [3:0] hr_ones,
                                          input logic [3:0] min_tens,
                                          input logic [3:0] min_ones);
      logic [7:0] hour;
      hour = 8'(hr_tens) * 8'd10 + 8'(hr_ones);
      return (hour >= HOUR_MIN) && (hour <= HOUR_MAX) &&
             (min_tens <= MIN_TENS_MAX) && (min_ones <= MIN_ONES_MAX);
   endfunction

endpackage

// File: rtl/key_digit_collector_debounce.sv
// Press/release qualifier: a key code must be seen stable for DEBOUNCE_CYCLES
// samples to be accepted, and the key must read low as long again to be released.
module key_debounce
   import key_digit_collector_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key,
   input  logic       key_pressed,
   output logic       accept_c,
   output logic [3:0] accept_key_c,
   output logic       release_done_c
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

   logic [1:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    candidate, candidate_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         candidate <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         candidate <= candidate_n;
      end
   end

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      candidate_n    = candidate;
      accept_c       = 1'b0;
      release_done_c = 1'b0;

      case (state)
         ST_IDLE: begin
            if (key_pressed && (key <= KEY_TIME)) begin
               candidate_n = key;
               cnt_n       = CW'(1);
               state_n     = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (!key_pressed) begin
               state_n = ST_IDLE;
            end else if (key != candidate) begin
               // A bounce onto an unused code abandons the press entirely.
               if (key <= KEY_TIME) begin
                  candidate_n = key;
                  cnt_n       = CW'(1);
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_HELD: begin
            if (!key_pressed) begin
               cnt_n   = CW'(1);
               state_n = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (key_pressed) begin
               state_n = ST_HELD;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // Count completion resolved after the per-state update so one sample suffices when allowed.
      if ((state_n == ST_DEBOUNCE) && (cnt_n == CNT_DONE)) begin
         accept_c = 1'b1;
         state_n  = ST_HELD;
      end
      if ((state_n == ST_RELEASE) && (cnt_n == CNT_DONE)) begin
         release_done_c = 1'b1;
         state_n        = ST_IDLE;
      end
   end

   assign accept_key_c = candidate_n;

endmodule

// File: rtl/key_digit_collector.sv
// Collects up to four debounced keypad digits and turns alarm/time keys into
// load commands once the entry passes the hh:mm range check.
module key_digit_collector
   import key_digit_collector_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_SECONDS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key,
   input  logic       key_pressed,
   input  logic       one_second,
   output logic [3:0] key_buffer_0,
   output logic [3:0] key_buffer_1,
   output logic [3:0] key_buffer_2,
   output logic [3:0] key_buffer_3,
   output logic [2:0] num_keys,
   output logic       entry_active,
   output logic       shift,
   output logic       load_new_a,
   output logic       load_new_c,
   output logic       show_a,
   output logic       entry_error
);

   localparam int unsigned TW = $clog2(TIMEOUT_SECONDS + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_SECONDS - 1);

   logic          accept_c;
   logic [3:0]    accept_key_c;
   logic          release_done_c;

   logic [3:0][3:0] buf_q, buf_n;
   logic [2:0]    num_n;
   logic [TW-1:0] tcnt, tcnt_n;
   logic          pend_clear, pend_clear_n;
   logic          shift_n, load_a_n, load_c_n, error_n, show_n;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk            (clk),
      .reset          (reset),
      .key            (key),
      .key_pressed    (key_pressed),
      .accept_c       (accept_c),
      .accept_key_c   (accept_key_c),
      .release_done_c (release_done_c)
   );

   always_comb begin
      buf_n        = buf_q;
      num_n        = num_keys;
      tcnt_n       = tcnt;
      pend_clear_n = 1'b0;
      shift_n      = 1'b0;
      load_a_n     = 1'b0;
      load_c_n     = 1'b0;
      error_n      = 1'b0;
      show_n       = show_a;

      // Buffers stay readable during a load/error pulse and empty one cycle later.
      if (pend_clear) begin
         buf_n = '0;
         num_n = 3'd0;
      end
      if (release_done_c) show_n = 1'b0;

      if (accept_c) begin
         tcnt_n = '0;
         if (accept_key_c <= DIGIT_MAX) begin
            if (num_keys < MAX_KEYS) begin
               buf_n   = {buf_q[2], buf_q[1], buf_q[0], accept_key_c};
               num_n   = num_keys + 3'd1;
               shift_n = 1'b1;
            end else begin
               buf_n = '0;
               num_n = 3'd0;
            end
         end else if (num_keys == MAX_KEYS) begin
            pend_clear_n = 1'b1;
            if (time_in_range(buf_q[3], buf_q[2], buf_q[1], buf_q[0])) begin
               load_a_n = (accept_key_c == KEY_ALARM);
               load_c_n = (accept_key_c == KEY_TIME);
            end else begin
               error_n = 1'b1;
            end
         end else if (accept_key_c == KEY_ALARM) begin
            show_n = 1'b1;
         end
      end else if (num_keys == 3'd0) begin
         tcnt_n = '0;
      end else if (one_second) begin
         if (tcnt == TIMEOUT_LAST) begin
            buf_n  = '0;
            num_n  = 3'd0;
            tcnt_n = '0;
         end else begin
            tcnt_n = tcnt + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q        <= '0;
         num_keys     <= 3'd0;
         entry_active <= 1'b0;
         tcnt         <= '0;
         pend_clear   <= 1'b0;
         shift        <= 1'b0;
         load_new_a   <= 1'b0;
         load_new_c   <= 1'b0;
         entry_error  <= 1'b0;
         show_a       <= 1'b0;
      end else begin
         buf_q        <= buf_n;
         num_keys     <= num_n;
         entry_active <= (num_n != 3'd0);
         tcnt         <= tcnt_n;
         pend_clear   <= pend_clear_n;
         shift        <= shift_n;
         load_new_a   <= load_a_n;
         load_new_c   <= load_c_n;
         entry_error  <= error_n;
         show_a       <= show_n;
      end
   end

   assign key_buffer_0 = buf_q[0];
   assign key_buffer_1 = buf_q[1];
   assign key_buffer_2 = buf_q[2];
   assign key_buffer_3 = buf_q[3];

endmodule

// File: tb/tb_key_digit_collector.sv
// Scoreboard bench for key_digit_collector: stimulus pushes expected pulses,
// a negedge monitor pops and compares every shift/load/error pulse.
module tb_key_digit_collector;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key;
   logic       key_pressed;
   logic       one_second;
   logic [3:0] key_buffer_0, key_buffer_1, key_buffer_2, key_buffer_3;
   logic [2:0] num_keys;
   logic       entry_active, shift, load_new_a, load_new_c, show_a, entry_error;

   localparam logic [2:0] EV_SHIFT = 3'd1;
   localparam logic [2:0] EV_LOADA = 3'd2;
   localparam logic [2:0] EV_LOADC = 3'd3;
   localparam logic [2:0] EV_ERROR = 3'd4;
   localparam logic [2:0] EV_MULTI = 3'd7;

   typedef struct packed {
      logic [2:0]  kind;
      logic [15:0] bufs;
      logic [2:0]  num;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   logic chk_clear = 1'b0;

   key_digit_collector #(
      .DEBOUNCE_CYCLES (4),
      .TIMEOUT_SECONDS (10)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key          (key),
      .key_pressed  (key_pressed),
      .one_second   (one_second),
      .key_buffer_0 (key_buffer_0),
      .key_buffer_1 (key_buffer_1),
      .key_buffer_2 (key_buffer_2),
      .key_buffer_3 (key_buffer_3),
      .num_keys     (num_keys),
      .entry_active (entry_active),
      .shift        (shift),
      .load_new_a   (load_new_a),
      .load_new_c   (load_new_c),
      .show_a       (show_a),
      .entry_error  (entry_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] bufs_now();
      return {key_buffer_3, key_buffer_2, key_buffer_1, key_buffer_0};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_ev(input logic [2:0] kind, input logic [15:0] bufs, input logic [2:0] num);
      exp_q.push_back('{kind: kind, bufs: bufs, num: num});
   endtask

   task automatic press(input logic [3:0] k);
      key = k;
      key_pressed = 1'b1;
      step(6);
      key_pressed = 1'b0;
      step(6);
   endtask

   task automatic pulse_second();
      one_second = 1'b1;
      step(1);
      one_second = 1'b0;
      step(2);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      key = 4'd0;
      key_pressed = 1'b0;
      one_second = 1'b0;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   // Monitor: every command pulse must match the next expected event.
   always @(negedge clk) begin
      logic [2:0] kind;
      ev_t got, want;
      if (!reset) begin
         if (chk_clear) begin
            check("cleared_after_cmd", 32'(num_keys), 32'd0);
            chk_clear = 1'b0;
         end
         if (shift || load_new_a || load_new_c || entry_error) begin
            case ({shift, load_new_a, load_new_c, entry_error})
               4'b1000: kind = EV_SHIFT;
               4'b0100: kind = EV_LOADA;
               4'b0010: kind = EV_LOADC;
               4'b0001: kind = EV_ERROR;
               default: kind = EV_MULTI;
            endcase
            got = '{kind: kind, bufs: bufs_now(), num: num_keys};
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", 32'(got), 32'd0);
            end else begin
               want = exp_q.pop_front();
               check("cmd_event", 32'(got), 32'(want));
            end
            if (kind inside {EV_LOADA, EV_LOADC, EV_ERROR}) chk_clear = 1'b1;
         end
      end
   end

   initial begin
      do_reset();
      check("reset_num", 32'(num_keys), 32'd0);
      check("reset_outs", {bufs_now(), 8'(entry_active), 8'(show_a)}, 32'd0);

      // Valid alarm entry 07:30
      expect_ev(EV_SHIFT, 16'h0000, 3'd1); press(4'd0);
      check("active_one_digit", 32'(entry_active), 32'd1);
      expect_ev(EV_SHIFT, 16'h0007, 3'd2); press(4'd7);
      expect_ev(EV_SHIFT, 16'h0073, 3'd3); press(4'd3);
      expect_ev(EV_SHIFT, 16'h0730, 3'd4); press(4'd0);
      expect_ev(EV_LOADA, 16'h0730, 3'd4); press(4'hA);
      check("alarm_cleared", {16'(bufs_now()), 8'(num_keys), 8'(entry_active)}, 32'd0);

      // Bouncing 5 accepted exactly once
      key = 4'd5;
      repeat (3) begin
         key_pressed = 1'b1; step(2);
         key_pressed = 1'b0; step(1);
      end
      expect_ev(EV_SHIFT, 16'h0005, 3'd1);
      key_pressed = 1'b1; step(4);
      key_pressed = 1'b0; step(6);
      check("bounce_buf0", 32'(key_buffer_0), 32'd5);
      do_reset();
      check("reset_mid_entry", {16'(bufs_now()), 8'(num_keys), 8'(entry_active)}, 32'd0);

      // Hour 13 fails the range check on a time key
      expect_ev(EV_SHIFT, 16'h0001, 3'd1); press(4'd1);
      expect_ev(EV_SHIFT, 16'h0013, 3'd2); press(4'd3);
      expect_ev(EV_SHIFT, 16'h0130, 3'd3); press(4'd0);
      expect_ev(EV_SHIFT, 16'h1300, 3'd4); press(4'd0);
      expect_ev(EV_ERROR, 16'h1300, 3'd4); press(4'hB);
      check("error_cleared", {16'(bufs_now()), 8'(num_keys)}, 32'd0);

      // 12:59 is the upper boundary and loads the clock
      expect_ev(EV_SHIFT, 16'h0001, 3'd1); press(4'd1);
      expect_ev(EV_SHIFT, 16'h0012, 3'd2); press(4'd2);
      expect_ev(EV_SHIFT, 16'h0125, 3'd3); press(4'd5);
      expect_ev(EV_SHIFT, 16'h1259, 3'd4); press(4'd9);
      expect_ev(EV_LOADC, 16'h1259, 3'd4); press(4'hB);

      // Hour 00 fails on alarm key
      expect_ev(EV_SHIFT, 16'h0000, 3'd1); press(4'd0);
      expect_ev(EV_SHIFT, 16'h0000, 3'd2); press(4'd0);
      expect_ev(EV_SHIFT, 16'h0000, 3'd3); press(4'd0);
      expect_ev(EV_SHIFT, 16'h0000, 3'd4); press(4'd0);
      expect_ev(EV_ERROR, 16'h0000, 3'd4); press(4'hA);

      // Minute 60 fails
      expect_ev(EV_SHIFT, 16'h0000, 3'd1); press(4'd0);
      expect_ev(EV_SHIFT, 16'h0001, 3'd2); press(4'd1);
      expect_ev(EV_SHIFT, 16'h0016, 3'd3); press(4'd6);
      expect_ev(EV_SHIFT, 16'h0160, 3'd4); press(4'd0);
      expect_ev(EV_ERROR, 16'h0160, 3'd4); press(4'hB);

      // Fifth digit discards the entry silently
      expect_ev(EV_SHIFT, 16'h0001, 3'd1); press(4'd1);
      expect_ev(EV_SHIFT, 16'h0012, 3'd2); press(4'd2);
      expect_ev(EV_SHIFT, 16'h0123, 3'd3); press(4'd3);
      expect_ev(EV_SHIFT, 16'h1234, 3'd4); press(4'd4);
      press(4'd5);
      check("fifth_digit_clear", {16'(bufs_now()), 8'(num_keys)}, 32'd0);

      // Time key on a partial entry does nothing; unused code ignored
      expect_ev(EV_SHIFT, 16'h0003, 3'd1); press(4'd3);
      press(4'hB);
      press(4'hE);
      check("partial_time_key", {16'(bufs_now()), 8'(num_keys)}, {16'h0003, 8'd1});

      // Timeout: 9 pulses keep the entry, the 10th clears it
      do_reset();
      expect_ev(EV_SHIFT, 16'h0001, 3'd1); press(4'd1);
      expect_ev(EV_SHIFT, 16'h0012, 3'd2); press(4'd2);
      repeat (9) pulse_second();
      check("nine_seconds_kept", {16'(bufs_now()), 8'(num_keys)}, {16'h0012, 8'd2});
      pulse_second();
      check("timeout_clear", {16'(bufs_now()), 8'(num_keys), 8'(entry_active)}, 32'd0);

      // A key after 9 pulses restarts the count
      expect_ev(EV_SHIFT, 16'h0001, 3'd1); press(4'd1);
      expect_ev(EV_SHIFT, 16'h0012, 3'd2); press(4'd2);
      repeat (9) pulse_second();
      expect_ev(EV_SHIFT, 16'h0123, 3'd3); press(4'd3);
      repeat (9) pulse_second();
      check("timeout_restart", {16'(bufs_now()), 8'(num_keys)}, {16'h0123, 8'd3});

      // Alarm key with no entry shows alarm while held
      do_reset();
      key = 4'hA; key_pressed = 1'b1;
      step(3);
      check("show_a_before_accept", 32'(show_a), 32'd0);
      step(1);
      check("show_a_at_accept", 32'(show_a), 32'd1);
      step(5);
      key_pressed = 1'b0;
      step(3);
      check("show_a_releasing", 32'(show_a), 32'd1);
      step(1);
      check("show_a_released", 32'(show_a), 32'd0);

      // Reset on the 3rd debounce cycle of key 9
      expect_ev(EV_SHIFT, 16'h0004, 3'd1); press(4'd4);
      key = 4'd9; key_pressed = 1'b1;
      step(2);
      reset = 1'b1; key_pressed = 1'b0;
      step(1);
      reset = 1'b0;
      step(1);
      check("reset_mid_debounce",
            {bufs_now(), 3'(num_keys), entry_active, shift, load_new_a, load_new_c,
             show_a, entry_error, 9'd0}, 32'd0);
      step(6);
      expect_ev(EV_SHIFT, 16'h0009, 3'd1); press(4'd9);
      check("clean_press_after_reset", {16'(bufs_now()), 8'(num_keys)}, {16'h0009, 8'd1});

      step(4);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_digit_collector.md
KEY_DIGIT_COLLECTOR -- requirements
Module: key_digit_collector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable clk samples required to accept a press or a release.
REQ-002 Parameter TIMEOUT_SECONDS, default 10: one_second pulses with no accepted key before partial entry is discarded.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key  input  4  raw key code from keypad decode: 0-9 digit, 4'hA alarm, 4'hB time, 4'hC-4'hF unused.
REQ-006 key_pressed  input  1  raw level, high while any key is physically down.
REQ-007 one_second  input  1  single-cycle pulse once per second.
REQ-008 key_buffer_0..key_buffer_3  output  4 each  entered digits: 0 = newest (LS min), 3 = oldest (MS hr).
REQ-009 num_keys  output  3  digits held, 0..4.
REQ-010 entry_active  output  1  high while num_keys != 0.
REQ-011 shift  output  1  one-cycle pulse on each accepted digit.
REQ-012 load_new_a / load_new_c  output  1 each  one-cycle pulse: buffer is a valid new alarm / current time.
REQ-013 show_a  output  1  level, high while a debounced alarm key is held with num_keys < 4.
REQ-014 entry_error  output  1  one-cycle pulse when a 4-digit entry fails range check.

Function
REQ-015 FSM states: IDLE, DEBOUNCE, HELD, RELEASE; reset state IDLE.
REQ-016 IDLE -> DEBOUNCE when key_pressed=1 and key <= 4'hB; latch key as candidate, stable count = 1.
REQ-017 DEBOUNCE: if key_pressed=1 and key == candidate, increment; if code changes, reload candidate with count 1; if key_pressed=0, return to IDLE.
REQ-018 On the edge where count reaches DEBOUNCE_CYCLES, perform the accept action (REQ-020..REQ-024) and enter HELD; outputs are visible the following cycle.
REQ-019 HELD: no further action. When key_pressed=0, enter RELEASE. RELEASE returns to IDLE after DEBOUNCE_CYCLES consecutive low samples; any high sample returns to HELD.
REQ-020 Digit, num_keys < 4: shift buffer (3<=2, 2<=1, 1<=0, 0<=key), increment num_keys, pulse shift.
REQ-021 Digit, num_keys == 4 (fifth digit): clear all buffers to 0 and set num_keys=0; no shift pulse.
REQ-022 Alarm or time key, num_keys == 4: range check. Buffer 3:2 as hour 01..12; buffer 1:0 as minute 00..59; key_buffer_1 <= 5.
REQ-023 Range check pass: pulse load_new_a (alarm key) or load_new_c (time key); buffers stay valid during the pulse; clear buffers and num_keys on the next edge.
REQ-024 Range check fail: pulse entry_error, then clear buffers and num_keys.
REQ-025 Alarm key with num_keys < 4: show_a=1 from accept until RELEASE completes; buffer unchanged. Time key with num_keys < 4: no action.
REQ-026 Codes 4'hC-4'hF never leave IDLE.
REQ-027 Timeout counter: cleared on every accept and whenever num_keys=0. While entry_active, increments on one_second. On reaching TIMEOUT_SECONDS, clear buffers and num_keys.
REQ-028 An accept and a timeout in the same cycle: accept wins and the counter clears.
REQ-029 load_new_a, load_new_c, entry_error and shift are mutually exclusive; each is exactly one cycle per accept.

Reset
REQ-030 Reset clears all outputs, buffers, num_keys, counters, candidate and FSM to IDLE; it is effective mid-debounce or mid-entry with no pulse emitted.

Structure
REQ-031 Shared package holds KEY_ALARM=4'hA, KEY_TIME=4'hB, the FSM state encodings and the hour/minute limits.
REQ-032 Sub-module key_debounce holds the candidate register, stable counter, and press/release qualification; key_digit_collector holds buffer, timeout and command logic.

Verification
REQ-033 Keys 0,7,3,0 (each held 6 cycles, released 6), then A -> load_new_a single pulse with buffers 0,7,3,0 (3..0); num_keys=0 next cycle.
REQ-034 Key 5 bouncing (high 2 cycles, low 1, repeated), then stable 4 cycles -> exactly one shift; key_buffer_0=5.
REQ-035 Keys 1,3,0,0 then B -> entry_error pulse, no load_new_c; buffers cleared.
REQ-036 Keys 1,2 then 10 one_second pulses with no key -> buffers and num_keys cleared on the 10th pulse; 9 pulses then a key -> no clear.
REQ-037 Alarm key held with num_keys=0 -> show_a high from accept until release debounced; no load pulse.
REQ-038 Reset asserted on the 3rd debounce cycle of key 9 -> no shift; all outputs 0; the next clean press is accepted normally.
